// File: rtl/l2_mem_refill_pkg.sv
// Shared constants for the L2 memory refill path: bus geometry, direction codes, FSM encodings.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package l2_mem_refill_pkg;

  localparam int BEAT_W      = 128;
  localparam int BEATS       = 4;
  localparam int LINE_W      = BEAT_W * BEATS;
  localparam int LINE_ADDR_W = 26;
  localparam int BEAT_CNT_W  = 2;
  localparam int MEM_BEATS   = 4;
  localparam int BUS_ADDR_W  = LINE_ADDR_W + BEAT_CNT_W;

  // Transfer direction as seen on mem_rw / bus_rw.
  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  // Refill FSM encodings.
  localparam logic [1:0] MEM_IDLE = 2'd0;
  localparam logic [1:0] MEM_XFER = 2'd1;
  localparam logic [1:0] MEM_DONE = 2'd2;

  // Beat index advance; wraps 3 -> 0 without touching the line address.
  function automatic logic [BEAT_CNT_W-1:0] next_beat(input logic [BEAT_CNT_W-1:0] b);
    return BEAT_CNT_W'(b + 1'b1);
  endfunction

endpackage

// File: rtl/l2_mem_refill_line_buf.sv
// Line buffer: 4x128 refill register file (beat write port) plus latched write-back line (beat read mux).
// Latency: beat writes and line loads visible the cycle after the write; read mux is combinational.
// Backpressure: none; the owner decides when to write.
module l2_line_buf
  import l2_mem_refill_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_load,
  input  logic [LINE_W-1:0]     wb_line,
  input  logic [BEAT_CNT_W-1:0] rd_beat,
  output logic [BEAT_W-1:0]     rd_data,
  input  logic                  fill_en,
  input  logic [BEAT_CNT_W-1:0] fill_beat,
  input  logic [BEAT_W-1:0]     fill_data,
  output logic [LINE_W-1:0]     line
);

  logic [BEAT_W-1:0] fill_q [BEATS];
  logic [BEAT_W-1:0] wb_q   [BEATS];

  // Refill beats land in their own slot; write-back line is captured whole at request accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BEATS; i++) begin
        fill_q[i] <= '0;
        wb_q[i]   <= '0;
      end
    end else begin
      if (wb_load) begin
        for (int i = 0; i < BEATS; i++) begin
          wb_q[i] <= wb_line[i*BEAT_W +: BEAT_W];
        end
      end
      if (fill_en) begin
        fill_q[fill_beat] <= fill_data;
      end
    end
  end

  assign rd_data = wb_q[rd_beat];

  for (genvar g = 0; g < BEATS; g++) begin : g_line
    assign line[g*BEAT_W +: BEAT_W] = fill_q[g];
  end

endmodule

// File: rtl/l2_mem_refill.sv
// Memory-side responder for the L2 I-cache: moves one 512-bit line as four 128-bit beats (macro L2_CRIT_BEAT_FIRST_EN: critical beat first).
// Latency: request accepted in idle, bus_req on the next 4 cycles with no waits, L2_complete one cycle after the 4th ack.
// Backpressure: each beat holds bus_req/bus_addr/bus_wdata stable until bus_ack; mem_req is ignored while busy.
module l2_mem_refill
  import l2_mem_refill_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mem_req,
  input  logic [LINE_ADDR_W-1:0] mem_addr,
  input  logic                   mem_rw,
  input  logic [BEAT_CNT_W-1:0]  mem_offset,
  input  logic [LINE_W-1:0]      wb_line,
  output logic [LINE_W-1:0]      line_rd,
  output logic                   L2_complete,
  output logic                   mem_busy,
  output logic                   bus_req,
  output logic                   bus_rw,
  output logic [BUS_ADDR_W-1:0]  bus_addr,
  output logic [BEAT_W-1:0]      bus_wdata,
  input  logic [BEAT_W-1:0]      bus_rdata,
`ifdef L2_CRIT_BEAT_FIRST_EN
  output logic                   crit_valid,
  output logic [BEAT_W-1:0]      crit_data,
`endif
  input  logic                   bus_ack
);

  localparam logic [BEAT_CNT_W-1:0] LAST_CNT = BEAT_CNT_W'(MEM_BEATS - 1);

  logic [1:0]             state_q;
  logic [BEAT_CNT_W-1:0]  beat_q;
  logic [BEAT_CNT_W-1:0]  cnt_q;
  logic [LINE_ADDR_W-1:0] addr_q;
  logic                   rw_q;
  logic [BEAT_CNT_W-1:0]  start_beat;
  logic                   accept;
  logic                   beat_ack;
  logic                   fill_en;
  logic [BEAT_W-1:0]      wb_beat;

`ifdef L2_CRIT_BEAT_FIRST_EN
  // Reads begin at the beat the core is waiting on; writes always stream from beat 0.
  assign start_beat = (mem_rw == READ) ? mem_offset : '0;
`else
  logic unused_offset;
  assign start_beat    = '0;
  assign unused_offset = ^mem_offset;
`endif

  assign accept   = (state_q == MEM_IDLE) && mem_req;
  assign beat_ack = (state_q == MEM_XFER) && bus_ack;
  assign fill_en  = beat_ack && (rw_q == READ);

  // Transfer sequencer: idle -> one beat per ack -> single done cycle -> idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MEM_IDLE;
      beat_q  <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      rw_q    <= READ;
    end else begin
      case (state_q)
        MEM_IDLE: begin
          if (mem_req) begin
            addr_q  <= mem_addr;
            rw_q    <= mem_rw;
            beat_q  <= start_beat;
            cnt_q   <= '0;
            state_q <= MEM_XFER;
          end
        end
        MEM_XFER: begin
          if (bus_ack) begin
            beat_q <= next_beat(beat_q);
            cnt_q  <= next_beat(cnt_q);
            if (cnt_q == LAST_CNT) begin
              state_q <= MEM_DONE;
            end
          end
        end
        MEM_DONE: state_q <= MEM_IDLE;
        default:  state_q <= MEM_IDLE;
      endcase
    end
  end

`ifdef L2_CRIT_BEAT_FIRST_EN
  // Forward the first returned read beat one cycle after its ack so L1 can restart early.
  always_ff @(posedge clk) begin
    if (rst) begin
      crit_valid <= 1'b0;
      crit_data  <= '0;
    end else begin
      crit_valid <= fill_en && (cnt_q == '0);
      if (fill_en && (cnt_q == '0)) begin
        crit_data <= bus_rdata;
      end
    end
  end
`endif

  l2_line_buf u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .wb_load   (accept && (mem_rw == WRITE)),
    .wb_line   (wb_line),
    .rd_beat   (beat_q),
    .rd_data   (wb_beat),
    .fill_en   (fill_en),
    .fill_beat (beat_q),
    .fill_data (bus_rdata),
    .line      (line_rd)
  );

  // Bus and status outputs are decoded from registered state, so they cannot move without an ack.
  assign bus_req     = (state_q == MEM_XFER);
  assign mem_busy    = (state_q == MEM_XFER);
  assign L2_complete = (state_q == MEM_DONE);
  assign bus_rw      = rw_q;
  assign bus_addr    = {addr_q, beat_q};
  assign bus_wdata   = ((state_q == MEM_XFER) && (rw_q == WRITE)) ? wb_beat : '0;

endmodule

// File: tb/tb_l2_mem_refill.sv
// Randomised scoreboard bench for l2_mem_refill (optionally with L2_CRIT_BEAT_FIRST_EN).
// Driver pushes expected beats/completions at request time; a monitor pops them on handshakes.
// Bus responder inserts random wait states and returns address-derived data.
module tb_l2_mem_refill;
  import l2_mem_refill_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          mem_req;
  logic [25:0]   mem_addr;
  logic          mem_rw;
  logic [1:0]    mem_offset;
  logic [511:0]  wb_line;
  logic [511:0]  line_rd;
  logic          L2_complete;
  logic          mem_busy;
  logic          bus_req;
  logic          bus_rw;
  logic [27:0]   bus_addr;
  logic [127:0]  bus_wdata;
  logic [127:0]  bus_rdata;
  logic          bus_ack;
`ifdef L2_CRIT_BEAT_FIRST_EN
  logic          crit_valid;
  logic [127:0]  crit_data;
`endif

  l2_mem_refill dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_rw      (mem_rw),
    .mem_offset  (mem_offset),
    .wb_line     (wb_line),
    .line_rd     (line_rd),
    .L2_complete (L2_complete),
    .mem_busy    (mem_busy),
    .bus_req     (bus_req),
    .bus_rw      (bus_rw),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_rdata   (bus_rdata),
`ifdef L2_CRIT_BEAT_FIRST_EN
    .crit_valid  (crit_valid),
    .crit_data   (crit_data),
`endif
    .bus_ack     (bus_ack)
  );

  typedef struct packed {
    logic [27:0]  addr;
    logic         rw;
    logic [127:0] wdata;
    logic         first;
  } beat_t;

  typedef struct packed {
    logic         rw;
    logic [511:0] line;
  } cmp_t;

  beat_t        beat_q[$];
  cmp_t         cmp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           wait_cnt = 0;
  int           issue_wc = 0;
  int           ack_mode = 0;
  logic [511:0] model_line = '0;
  logic [31:0]  salt_a, salt_b, salt_c;

  // Memory contents as a pure function of the beat address.
  function automatic logic [127:0] beat_data(input logic [27:0] a);
    return {salt_a ^ {4'h0, a}, salt_b + {4'h0, a}, ~{4'h0, a}, salt_c ^ {a, 4'h5}};
  endfunction

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Called right after a negedge: drive the request and push what the spec says must follow.
  task automatic issue(input logic [25:0] a, input logic rw, input logic [511:0] wl, input logic [1:0] off);
    logic [1:0] s;
    logic [1:0] bi;
    beat_t b;
    cmp_t c;
    mem_req = 1'b1; mem_addr = a; mem_rw = rw; wb_line = wl; mem_offset = off;
    s = 2'd0;
`ifdef L2_CRIT_BEAT_FIRST_EN
    if (rw == READ) s = off;
`endif
    c.rw = rw;
    c.line = model_line;
    for (int i = 0; i < 4; i++) begin
      bi = s + 2'(i);
      b.addr  = {a, bi};
      b.rw    = rw;
      b.wdata = wl[bi*128 +: 128];
      b.first = (i == 0);
      if (rw == READ) c.line[bi*128 +: 128] = beat_data({a, bi});
      beat_q.push_back(b);
    end
    if (rw == READ) model_line = c.line;
    cmp_q.push_back(c);
    issue_wc = wait_cnt;
  endtask

  // Wait (bounded) for L2_complete and check the cycle count against base + wait states.
  task automatic wait_done(input bit keep, input int base, input string name);
    int n;
    bit seen;
    n = 0; seen = 0;
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      if (L2_complete) seen = 1;
    end
    if (!seen) begin
      checks++; errors++;
      $display("FAIL %s timeout got=no L2_complete exp=L2_complete", name);
      beat_q.delete(); cmp_q.delete();
    end else begin
      check({name, "_latency"}, 512'(n), 512'(base + wait_cnt - issue_wc));
    end
    if (!keep) mem_req = 1'b0;
  endtask

  // Bus responder and scoreboard monitor, both evaluated at the negedge for the coming handshake.
  initial begin
    beat_t b;
    cmp_t c;
    bit prev_hold;
    logic [27:0] prev_addr;
    logic [127:0] prev_wdata;
    bit crit_due;
    logic [127:0] crit_exp;
    bus_ack = 1'b0; bus_rdata = '0;
    prev_hold = 0; prev_addr = '0; prev_wdata = '0; crit_due = 0; crit_exp = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus_ack = 1'b0; prev_hold = 0; crit_due = 0;
        continue;
      end
`ifdef L2_CRIT_BEAT_FIRST_EN
      if (crit_due || crit_valid) begin
        check("crit_valid", 512'(crit_valid), 512'(crit_due));
        if (crit_due) check("crit_data", 512'(crit_data), 512'(crit_exp));
      end
      crit_due = 0;
`endif
      if (prev_hold && bus_req) begin
        check("hold_addr", 512'(bus_addr), 512'(prev_addr));
        check("hold_wdata", 512'(bus_wdata), 512'(prev_wdata));
      end
      bus_ack   = (ack_mode == 1) ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus_rdata = bus_req ? beat_data(bus_addr) : {4{$urandom}};
      if (bus_req && bus_ack) begin
        if (beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat got=addr %h exp=no beat", bus_addr);
        end else begin
          b = beat_q.pop_front();
          check("bus_addr", 512'(bus_addr), 512'(b.addr));
          check("bus_rw", 512'(bus_rw), 512'(b.rw));
          if (b.rw == WRITE) check("bus_wdata", 512'(bus_wdata), 512'(b.wdata));
          check("mem_busy", 512'(mem_busy), 512'(1));
`ifdef L2_CRIT_BEAT_FIRST_EN
          if (b.first && b.rw == READ) begin
            crit_due = 1;
            crit_exp = beat_data(b.addr);
          end
`endif
        end
      end
      if (bus_req && !bus_ack) wait_cnt++;
      prev_hold  = bus_req && !bus_ack;
      prev_addr  = bus_addr;
      prev_wdata = bus_wdata;
      if (L2_complete) begin
        if (cmp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_complete got=1 exp=0");
        end else begin
          c = cmp_q.pop_front();
          check("line_rd", line_rd, c.line);
          check("done_bus_req", 512'(bus_req), 512'(0));
          check("done_mem_busy", 512'(mem_busy), 512'(0));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=still running exp=finished");
    $fatal(1, "watchdog");
  end

  // Driver: directed cases from the test plan, then a randomised mix.
  initial begin
    bit keep;
    bit prev_keep;
    logic rw;
    salt_a = $urandom; salt_b = $urandom; salt_c = $urandom;
    rst = 1'b1; mem_req = 1'b0; mem_addr = '0; mem_rw = READ; mem_offset = '0; wb_line = '0;
    repeat (3) @(negedge clk);
    check("rst_line_rd", line_rd, '0);
    check("rst_complete", 512'(L2_complete), 512'(0));
    check("rst_busy", 512'(mem_busy), 512'(0));
    check("rst_bus_req", 512'(bus_req), 512'(0));
    check("rst_bus_rw", 512'(bus_rw), 512'(0));
    check("rst_bus_addr", 512'(bus_addr), 512'(0));
    check("rst_bus_wdata", 512'(bus_wdata), 512'(0));
`ifdef L2_CRIT_BEAT_FIRST_EN
    check("rst_crit_valid", 512'(crit_valid), 512'(0));
`endif
    rst = 1'b0;

    // Read, no wait states: beats 48C..48F, completion 5 cycles after request.
    ack_mode = 1;
    @(negedge clk);
    issue(26'h0000123, READ, '0, 2'd0);
    wait_done(0, 5, "read_nowait");

    // Write with no waits: data streamed beat 0..3, line_rd keeps the previous read.
    @(negedge clk);
    issue(26'h0001F00, WRITE, {16{$urandom}}, 2'd2);
    wait_done(0, 5, "write_nowait");

    // Read with random waits.
    ack_mode = 0;
    @(negedge clk);
    issue(26'h0003AAA, READ, '0, 2'd1);
    wait_done(0, 5, "read_wait");

    // Reset after the second ack: bus_req drops, no completion, next read is clean.
    ack_mode = 1;
    @(negedge clk);
    issue(26'h2ABCDEF, READ, '0, 2'd0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1; mem_req = 1'b0;
    @(posedge clk); #2;
    check("rst_mid_bus_req", 512'(bus_req), 512'(0));
    check("rst_mid_busy", 512'(mem_busy), 512'(0));
    check("rst_mid_complete", 512'(L2_complete), 512'(0));
    check("rst_mid_line", line_rd, '0);
    beat_q.delete(); cmp_q.delete(); model_line = '0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    issue(26'h0000456, READ, '0, 2'd0);
    wait_done(0, 5, "read_after_rst");

    // Held request: second transfer starts the cycle after L2_complete with the new address.
    ack_mode = 0;
    @(negedge clk);
    issue(26'h0000777, READ, '0, 2'd0);
    wait_done(1, 5, "held_first");
    issue(26'h0000200, READ, '0, 2'd0);
    wait_done(0, 6, "held_second");

    // Critical-beat-first ordering 3,0,1,2 when the feature is built in.
    @(negedge clk);
    issue(26'h0000999, READ, '0, 2'd3);
    wait_done(0, 5, "crit_off3");

    // Randomised mix of reads/writes, offsets, waits and held requests.
    keep = 0;
    for (int k = 0; k < 40; k++) begin
      prev_keep = keep;
      if (!prev_keep) @(negedge clk);
      rw = $urandom_range(0, 1) == 1 ? WRITE : READ;
      issue(26'($urandom), rw, {16{$urandom}}, 2'($urandom_range(0, 3)));
      keep = (k < 39) && ($urandom_range(0, 3) == 0);
      wait_done(keep, prev_keep ? 6 : 5, "rand");
    end

    repeat (10) @(negedge clk);
    check("beat_q_empty", 512'(beat_q.size()), 512'(0));
    check("cmp_q_empty", 512'(cmp_q.size()), 512'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_mem_refill.md
Name: l2_mem_refill

Overview:
- Memory-side responder for the L2 instruction cache controller.
- Accepts the controller's line request (mem_addr/mem_rw) and moves one 512-bit line as 128-bit beats over a single-beat request/ack memory bus.
- Read: assembles the four beats into the line written to the selected L2 data way, then pulses L2_complete.
- Write: serialises a 512-bit line out to memory.

Parameters:
- BEAT_W, 128, memory bus data width in bits.
- BEATS, 4, beats per line; LINE_W = BEAT_W*BEATS = 512.
- LINE_ADDR_W, 26, line address width (address bits [31:6]).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_req  in  1  line request from L2 controller; level, held until L2_complete
- mem_addr  in  26  line address, bits [31:6]
- mem_rw  in  1  `READ = refill, `WRITE = write line to memory
- mem_offset  in  2  critical beat index, address bits [5:4] (used only with feature)
- wb_line  in  512  line data for `WRITE requests
- line_rd  out  512  assembled refill line, to L2_dataN_wd
- L2_complete  out  1  one-cycle done pulse
- mem_busy  out  1  transfer in progress
- bus_req  out  1  beat request, held until bus_ack
- bus_rw  out  1  beat direction
- bus_addr  out  28  beat address = {line addr, beat}
- bus_wdata  out  128  write beat data
- bus_rdata  in  128  read beat data, valid with bus_ack
- bus_ack  in  1  beat accepted/returned

Behaviour:
- Reset (synchronous): state=MEM_IDLE, beat=0, and all outputs 0: line_rd, L2_complete, mem_busy, bus_req, bus_rw, bus_addr, bus_wdata.
- A reset mid-transfer discards any partial line and drops bus_req in the following cycle. No L2_complete is issued.

State machine:
- MEM_IDLE
  - mem_busy=0.
  - If mem_req=1: latch mem_addr, mem_rw and wb_line (write); set beat=start beat; mem_busy=1; go to MEM_XFER.
- MEM_XFER
  - bus_req=1, bus_rw=latched rw, bus_addr={addr,beat}.
  - On write, bus_wdata=wb_line[beat*128 +: 128].
  - On bus_ack: for a read, store bus_rdata into line_rd[beat*128 +: 128]; then beat=beat+1 mod 4.
  - After BEATS acks: drop bus_req, go to MEM_DONE.
  - Without bus_ack: hold every bus output stable.
- MEM_DONE
  - L2_complete=1 for exactly one cycle; mem_busy=0; go to MEM_IDLE.
  - line_rd is held unchanged until the next read transfer begins.

Handshake and timing rules:
- mem_req is sampled only in MEM_IDLE. A request asserted (or kept asserted) while busy is ignored; the controller clears it on L2_complete.
- mem_req still high in the cycle after MEM_DONE starts a new transfer.
- Latency: with bus_ack=1 every cycle, mem_req at cycle 0 gives bus_req at cycles 1–4 and L2_complete at cycle 5. Each wait cycle adds one.
- bus_ack while bus_req=0 is ignored.
- Beat counter is 2 bits and wraps 3→0; the line address never increments across the wrap.

Optional Feature:
Macro: L2_CRIT_BEAT_FIRST_EN
- Defined:
  - Start beat = mem_offset; beats are fetched wrap-around, e.g. offset 2 gives order 2,3,0,1.
  - Adds outputs crit_valid (1) and crit_data (128). crit_valid pulses for one cycle, the cycle after the first read beat's ack, with that beat's data, so the L1 can restart early.
  - L2_complete timing is unchanged.
  - Write transfers still start at beat 0.
- Undefined:
  - Start beat is always 0, mem_offset is unused, and the crit ports are absent.

Decomposition:
- Shared header icache.h gains:
  - state encodings `MEM_IDLE, `MEM_XFER, `MEM_DONE;
  - `BEAT_CNT_W = 2;
  - `MEM_BEATS = 4.
- `READ / `WRITE come from stddef.h.
- One sub-module, l2_line_buf: a 4×128 register file with a beat-indexed write port (refill) and a beat-indexed read mux (write-back data).

Test Plan:
- Read, no wait states: mem_addr=26'h0000123, mem_rw=`READ, bus_ack tied 1, beats return 128'hA0..A3 → bus_addr sequence 28'h000048C..000048F; L2_complete at cycle 5; line_rd={A3,A2,A1,A0}.
- Read with waits: bus_ack delayed 3 cycles on beat 1 → bus_addr and bus_req held stable; L2_complete at cycle 8; single pulse.
- Write: mem_rw=`WRITE, wb_line={D3,D2,D1,D0} → bus_wdata D0..D3 in order with bus_rw=`WRITE; line_rd unchanged; L2_complete after the 4th ack.
- Reset after the 2nd ack → bus_req=0 and state MEM_IDLE next cycle; no L2_complete; a following read completes normally.
- Held request: mem_req kept high through completion, with a new mem_addr=26'h0000200 → second transfer starts the cycle after L2_complete and uses the new address.
- With L2_CRIT_BEAT_FIRST_EN, mem_offset=3 → bus_addr low bits 3,0,1,2; crit_valid one cycle after the first ack with the beat-3 data; line_rd correctly placed.
